// File: rtl/pusch_dr_pkg.sv
// Shared PUSCH data-rate defaults and control types for the beam power path.
package pusch_dr;

   localparam int BEAM_DEF  = 16;
   localparam int IW_DEF    = 48;
   localparam int SW_DEF    = 16;
   localparam int SHIFT_DEF = 20;
   localparam int AW_DEF    = 40;
   localparam int PWR_LAT   = 4;

   typedef struct packed {
      logic       vld;
      logic       first;
      logic       load;
      logic       symb_1st;
      logic [7:0] rbg_num;
   } ctl_t;

   function automatic logic [7:0] cnt_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

endpackage

// File: rtl/beam_pwr_acc.sv
// One beam: scale/saturate I and Q, square-sum, and accumulate with clamp.
module beam_pwr_acc
   import pusch_dr::*;
#(
   parameter int IW    = IW_DEF,
   parameter int SW    = SW_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic signed [IW-1:0] data_re_i,
   input  logic signed [IW-1:0] data_im_i,
   input  logic                 acc_en_i,
   input  logic                 first_i,
   input  logic                 load_i,
   input  logic                 clr_i,
   output logic [AW-1:0]        pwr_o,
   output logic                 sat_o
);

   localparam int SUMW = ((AW > 2*SW) ? AW : 2*SW) + 1;
   localparam logic signed [IW-1:0] XMAX = {{(IW-SW+1){1'b0}}, {(SW-1){1'b1}}};
   localparam logic signed [IW-1:0] XMIN = -XMAX;
   localparam logic [SUMW-1:0] AMAX = {{(SUMW-AW){1'b0}}, {AW{1'b1}}};

   logic signed [IW-1:0]   re_q, im_q;
   logic signed [SW-1:0]   re_s_q, im_s_q;
   logic [2*SW-1:0]        p_q;
   logic [AW-1:0]          acc_q, pwr_q;
   logic [SUMW-1:0]        base, sum;
   logic                   ovf;
   logic [AW-1:0]          sum_sat;

   // Symmetric clamp keeps +/- full scale at equal power.
   function automatic logic signed [SW-1:0] scale_sat(input logic signed [IW-1:0] d);
      logic signed [IW-1:0] s;
      s = d >>> SHIFT;
      if (s > XMAX) return XMAX[SW-1:0];
      if (s < XMIN) return XMIN[SW-1:0];
      return s[SW-1:0];
   endfunction

   function automatic logic [2*SW-1:0] pwr_sq(input logic signed [SW-1:0] a,
                                             input logic signed [SW-1:0] b);
      logic signed [2*SW-1:0] a2, b2;
      a2 = (2*SW)'(a) * (2*SW)'(a);
      b2 = (2*SW)'(b) * (2*SW)'(b);
      return $unsigned(a2) + $unsigned(b2);
   endfunction

   always_ff @(posedge clk_i) begin
      re_q   <= data_re_i;
      im_q   <= data_im_i;
      re_s_q <= scale_sat(re_q);
      im_s_q <= scale_sat(im_q);
      p_q    <= pwr_sq(re_s_q, im_s_q);
   end

   always_comb begin
      base    = first_i ? '0 : {{(SUMW-AW){1'b0}}, acc_q};
      sum     = base + {{(SUMW-2*SW){1'b0}}, p_q};
      ovf     = (sum > AMAX);
      sum_sat = ovf ? {AW{1'b1}} : sum[AW-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q <= '0;
         pwr_q <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
      end else if (acc_en_i) begin
         acc_q <= load_i ? '0 : sum_sat;
         if (load_i) pwr_q <= sum_sat;
      end
   end

   assign pwr_o = pwr_q;
   assign sat_o = acc_en_i & ovf;

endmodule

// File: rtl/beam_pwr_rbg.sv
// Per-beam RBG power: one accumulator per beam, shared RE-level control pipeline
// that tracks RBG boundaries, RE count and the symbol-first tag.
module beam_pwr_rbg
   import pusch_dr::*;
#(
   parameter int BEAM  = BEAM_DEF,
   parameter int IW    = IW_DEF,
   parameter int SW    = SW_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [BEAM-1:0][IW-1:0]  i_data_i,
   input  logic [BEAM-1:0][IW-1:0]  i_data_q,
   input  logic                     i_tvalid,
   input  logic                     i_sop,
   input  logic                     i_eop,
   input  logic                     i_rbg_load,
   input  logic [7:0]               i_rbg_num,
   input  logic                     i_symb_clr,
   input  logic                     i_symb_1st,
   output logic [BEAM-1:0][AW-1:0]  o_pwr,
   output logic                     o_pwr_vld,
   output logic [7:0]               o_rbg_num,
   output logic [7:0]               o_re_cnt,
   output logic                     o_symb_1st,
   output logic                     o_ovf
);

   logic       armed_q, armed_d;
   logic       open_q, open_d;
   logic       accept;
   ctl_t       ctl_in;
   ctl_t       ctl_q [PWR_LAT-1];
   ctl_t       s3;
   logic       acc_en;
   logic [BEAM-1:0] sat;
   logic [7:0] cnt_q, cnt_nxt;
   logic       s1st_q, s1st_nxt;

   // After reset, REs are ignored until a symbol boundary re-aligns us.
   always_comb begin
      ctl_in          = '0;
      accept          = i_tvalid & (armed_q | i_sop | i_symb_clr);
      armed_d         = armed_q | i_symb_clr | (i_tvalid & i_sop);
      ctl_in.vld      = accept;
      ctl_in.first    = i_sop | i_symb_clr | ~open_q;
      ctl_in.load     = i_rbg_load | i_eop;
      ctl_in.symb_1st = i_symb_1st;
      ctl_in.rbg_num  = i_rbg_num;
      open_d          = open_q;
      if (accept)          open_d = ~ctl_in.load;
      else if (i_symb_clr) open_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         armed_q <= 1'b0;
         open_q  <= 1'b0;
         for (int i = 0; i < PWR_LAT-1; i++) ctl_q[i] <= '0;
      end else begin
         armed_q  <= armed_d;
         open_q   <= open_d;
         ctl_q[0] <= ctl_in;
         for (int i = 1; i < PWR_LAT-1; i++) begin
            ctl_q[i] <= ctl_q[i-1];
            if (i_symb_clr) ctl_q[i].vld <= 1'b0;
         end
      end
   end

   assign s3     = ctl_q[PWR_LAT-2];
   assign acc_en = s3.vld & ~i_symb_clr;

   for (genvar b = 0; b < BEAM; b++) begin : g_beam
      beam_pwr_acc #(
         .IW    (IW),
         .SW    (SW),
         .SHIFT (SHIFT),
         .AW    (AW)
      ) u_acc (
         .clk_i     (i_clk),
         .rst_n_i   (i_rst_n),
         .data_re_i (i_data_i[b]),
         .data_im_i (i_data_q[b]),
         .acc_en_i  (acc_en),
         .first_i   (s3.first),
         .load_i    (s3.load),
         .clr_i     (i_symb_clr),
         .pwr_o     (o_pwr[b]),
         .sat_o     (sat[b])
      );
   end

   always_comb begin
      cnt_nxt  = cnt_inc(s3.first ? 8'd0 : cnt_q);
      s1st_nxt = s3.first ? s3.symb_1st : s1st_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q      <= '0;
         s1st_q     <= 1'b0;
         o_pwr_vld  <= 1'b0;
         o_rbg_num  <= '0;
         o_re_cnt   <= '0;
         o_symb_1st <= 1'b0;
         o_ovf      <= 1'b0;
      end else begin
         o_pwr_vld <= acc_en & s3.load;
         if (i_symb_clr) begin
            cnt_q  <= '0;
            s1st_q <= 1'b0;
            if (i_symb_1st) o_ovf <= 1'b0;
         end else begin
            if (|sat) o_ovf <= 1'b1;
            if (acc_en) begin
               cnt_q  <= s3.load ? 8'd0 : cnt_nxt;
               s1st_q <= s1st_nxt;
               if (s3.load) begin
                  o_rbg_num  <= s3.rbg_num;
                  o_re_cnt   <= cnt_nxt;
                  o_symb_1st <= s1st_nxt;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_beam_pwr_rbg.sv
// Directed bench for beam_pwr_rbg with a reference model feeding a scoreboard.
module tb_beam_pwr_rbg;

   localparam int BEAM  = 4;
   localparam int IW    = 48;
   localparam int SW    = 16;
   localparam int SHIFT = 20;
   localparam int AW    = 33;

   typedef struct packed {
      logic [BEAM-1:0][AW-1:0] pwr;
      int                      cyc;
      logic [7:0]              num;
      logic [7:0]              cnt;
      logic                    s1st;
      logic                    ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [BEAM-1:0][IW-1:0] di, dq;
   logic tvalid, sop, eop, load, clr, s1st;
   logic [7:0] num;
   logic [BEAM-1:0][AW-1:0] o_pwr;
   logic o_pwr_vld, o_symb_1st, o_ovf;
   logic [7:0] o_rbg_num, o_re_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   longint vi [BEAM];
   longint vq [BEAM];
   longint m_acc [BEAM];
   int     m_cnt;
   bit     m_s1st, m_open, m_armed, m_ovf;
   exp_t   sb [$];

   logic [BEAM-1:0][AW-1:0] last_pwr;
   logic [7:0] last_cnt, last_num;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   beam_pwr_rbg #(.BEAM(BEAM), .IW(IW), .SW(SW), .SHIFT(SHIFT), .AW(AW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data_i(di), .i_data_q(dq),
      .i_tvalid(tvalid), .i_sop(sop), .i_eop(eop), .i_rbg_load(load),
      .i_rbg_num(num), .i_symb_clr(clr), .i_symb_1st(s1st),
      .o_pwr(o_pwr), .o_pwr_vld(o_pwr_vld), .o_rbg_num(o_rbg_num),
      .o_re_cnt(o_re_cnt), .o_symb_1st(o_symb_1st), .o_ovf(o_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint scl(input longint d);
      longint x, mx;
      mx = (longint'(1) <<< (SW-1)) - 1;
      x  = d >>> SHIFT;
      if (x > mx)  x = mx;
      if (x < -mx) x = -mx;
      return x;
   endfunction

   task automatic set_all(input longint ai, input longint aq);
      for (int b = 0; b < BEAM; b++) begin
         vi[b] = ai;
         vq[b] = aq;
      end
   endtask

   task automatic idle(input int n);
      tvalid = 0; sop = 0; eop = 0; load = 0; clr = 0; s1st = 0;
      repeat (n) @(negedge clk);
   endtask

   task automatic re(input bit v, input bit f_sop, input bit f_eop, input bit f_load,
                     input bit f_clr, input bit f_s1st, input int f_num);
      exp_t   e;
      bit     acc_ok;
      longint x1, x2, amax;
      amax = (longint'(1) <<< AW) - 1;
      tvalid = v; sop = f_sop; eop = f_eop; load = f_load; clr = f_clr; s1st = f_s1st;
      num = f_num[7:0];
      for (int b = 0; b < BEAM; b++) begin
         di[b] = vi[b][IW-1:0];
         dq[b] = vq[b][IW-1:0];
      end
      if (f_clr) begin
         while (sb.size() > 0 && sb[sb.size()-1].cyc >= cyc + 1) void'(sb.pop_back());
         if (f_s1st) m_ovf = 0;
         m_open = 0;
      end
      acc_ok = v && (m_armed || f_sop || f_clr);
      if (f_clr || (v && f_sop)) m_armed = 1;
      if (acc_ok) begin
         if (f_sop || f_clr || !m_open) begin
            for (int b = 0; b < BEAM; b++) m_acc[b] = 0;
            m_cnt  = 0;
            m_s1st = f_s1st;
         end
         for (int b = 0; b < BEAM; b++) begin
            x1 = scl(vi[b]);
            x2 = scl(vq[b]);
            m_acc[b] = m_acc[b] + x1*x1 + x2*x2;
            if (m_acc[b] > amax) begin
               m_acc[b] = amax;
               m_ovf = 1;
            end
         end
         if (m_cnt < 255) m_cnt++;
         if (f_load || f_eop) begin
            for (int b = 0; b < BEAM; b++) e.pwr[b] = m_acc[b][AW-1:0];
            e.cyc  = cyc + 4;
            e.num  = f_num[7:0];
            e.cnt  = m_cnt[7:0];
            e.s1st = m_s1st;
            e.ovf  = m_ovf;
            sb.push_back(e);
            m_open = 0;
         end else begin
            m_open = 1;
         end
      end
      @(negedge clk);
   endtask

   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (!rst_n) begin
         last_pwr = '0;
         last_cnt = '0;
         last_num = '0;
      end else if (o_pwr_vld) begin
         chk("vld_expected", (sb.size() != 0) ? 1 : 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("latency", cyc, e.cyc);
            for (int b = 0; b < BEAM; b++) chk("pwr", o_pwr[b], e.pwr[b]);
            chk("rbg_num", o_rbg_num, e.num);
            chk("re_cnt", o_re_cnt, e.cnt);
            chk("symb_1st", o_symb_1st, e.s1st);
            chk("ovf", o_ovf, e.ovf);
         end
         last_pwr = o_pwr;
         last_cnt = o_re_cnt;
         last_num = o_rbg_num;
      end else begin
         chk("hold_out", ((o_pwr === last_pwr) && (o_re_cnt === last_cnt) &&
                          (o_rbg_num === last_num)) ? 1 : 0, 1);
      end
   end

   initial begin
      tvalid = 0; sop = 0; eop = 0; load = 0; clr = 0; s1st = 0; num = '0;
      di = '0; dq = '0;
      m_cnt = 0; m_s1st = 0; m_open = 0; m_armed = 0; m_ovf = 0;
      for (int b = 0; b < BEAM; b++) m_acc[b] = 0;
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_vld", o_pwr_vld, 0);
      chk("rst_pwr", (o_pwr === '0) ? 1 : 0, 1);
      chk("rst_num", o_rbg_num, 0);
      chk("rst_cnt", o_re_cnt, 0);
      chk("rst_s1st", o_symb_1st, 0);
      chk("rst_ovf", o_ovf, 0);
      rst_n = 1;
      @(negedge clk);

      // 12-RE RBG, equal beams
      set_all(longint'(100) <<< SHIFT, longint'(100) <<< SHIFT);
      for (int i = 1; i <= 12; i++) re(1, i == 1, 0, i == 12, 0, i == 1, 3);
      idle(6);
      chk("t12_pwr", o_pwr[2], 240000);
      chk("t12_cnt", o_re_cnt, 12);

      // back-to-back one-RE RBGs with per-beam data and negative floors
      for (int k = 0; k < 3; k++) begin
         for (int b = 0; b < BEAM; b++) begin
            vi[b] = longint'((b+1)*(k+3)) <<< SHIFT;
            vq[b] = -(longint'((b+2)*(k+1)) <<< SHIFT) - 1;
         end
         re(1, 1, 0, 1, 0, k[0], 10 + k);
      end
      idle(6);

      // gap-free vs gapped RBG of 4 REs
      for (int b = 0; b < BEAM; b++) begin
         vi[b] = (longint'(b*50+7) <<< SHIFT) + 12345;
         vq[b] = -(longint'(b*30+1) <<< SHIFT);
      end
      for (int i = 1; i <= 4; i++) re(1, i == 1, 0, i == 4, 0, 0, 20);
      idle(5);
      for (int i = 1; i <= 4; i++) begin
         re(1, i == 1, 0, i == 4, 0, 0, 21);
         if (i < 4) idle(3);
      end
      idle(6);

      // residue without eop discarded by the next sop
      set_all(longint'(5) <<< SHIFT, 0);
      for (int i = 1; i <= 3; i++) re(1, i == 1, 0, 0, 0, 0, 29);
      for (int i = 1; i <= 2; i++) re(1, i == 1, 0, i == 2, 0, 0, 30);
      idle(6);
      chk("sop_cnt", o_re_cnt, 2);
      chk("sop_pwr", o_pwr[0], 50);

      // symb_clr at RE 5 of 12
      set_all(longint'(10) <<< SHIFT, 0);
      for (int i = 1; i <= 12; i++) re(1, i == 1, 0, i == 12, i == 5, 0, 31);
      idle(6);
      chk("clr_cnt", o_re_cnt, 8);
      chk("clr_pwr", o_pwr[1], 800);
      re(1, 1, 0, 1, 0, 0, 32);
      re(0, 0, 0, 0, 1, 0, 0);
      idle(6);
      chk("clr_drop_num", o_rbg_num, 31);

      // eop flush and RE-count saturation
      set_all(longint'(2) <<< SHIFT, longint'(1) <<< SHIFT);
      for (int i = 1; i <= 7; i++) re(1, i == 1, i == 7, 0, 0, 0, 40);
      idle(6);
      chk("eop_cnt", o_re_cnt, 7);
      set_all(longint'(1) <<< SHIFT, longint'(1) <<< SHIFT);
      for (int i = 1; i <= 300; i++) re(1, i == 1, 0, i == 300, 0, 0, 41);
      idle(6);
      chk("sat_cnt", o_re_cnt, 255);
      chk("sat_cnt_pwr", o_pwr[3], 600);

      // input clamp and accumulator overflow
      set_all((longint'(1) <<< 47) - 1, 0);
      re(1, 1, 0, 1, 0, 0, 50);
      idle(6);
      chk("clamp_pos", o_pwr[0], 64'd1073676289);
      chk("ovf_clear", o_ovf, 0);
      set_all(-(longint'(1) <<< 47), 0);
      re(1, 1, 0, 1, 0, 0, 51);
      idle(6);
      chk("clamp_neg", o_pwr[1], 64'd1073676289);
      set_all((longint'(1) <<< 47) - 1, (longint'(1) <<< 47) - 1);
      for (int i = 1; i <= 5; i++) re(1, i == 1, 0, i == 5, 0, 0, 52);
      idle(6);
      chk("ovf_pwr", o_pwr[2], 64'd8589934591);
      chk("ovf_set", o_ovf, 1);
      set_all(longint'(1) <<< SHIFT, 0);
      re(1, 1, 0, 1, 0, 0, 53);
      idle(6);
      chk("ovf_sticky", o_ovf, 1);
      re(0, 0, 0, 0, 1, 0, 0);
      idle(3);
      chk("ovf_keep_clr", o_ovf, 1);

      // reset pulse mid-RBG, then REs ignored until sop
      set_all(longint'(3) <<< SHIFT, 0);
      for (int i = 1; i <= 3; i++) re(1, i == 1, 0, 0, 0, 0, 55);
      idle(1);
      rst_n = 0;
      #1;
      chk("mid_rst_vld", o_pwr_vld, 0);
      chk("mid_rst_pwr", (o_pwr === '0) ? 1 : 0, 1);
      chk("mid_rst_num", o_rbg_num, 0);
      chk("mid_rst_cnt", o_re_cnt, 0);
      chk("mid_rst_ovf", o_ovf, 0);
      m_armed = 0; m_open = 0; m_ovf = 0; m_cnt = 0;
      sb.delete();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      for (int i = 1; i <= 3; i++) re(1, 0, 0, i == 3, 0, 0, 56);
      idle(6);
      chk("post_rst_silent", o_re_cnt, 0);
      for (int i = 1; i <= 2; i++) re(1, i == 1, 0, i == 2, 0, 1, 57);
      idle(6);
      chk("post_rst_cnt", o_re_cnt, 2);

      // overflow cleared only by symb_clr with symb_1st
      set_all((longint'(1) <<< 47) - 1, (longint'(1) <<< 47) - 1);
      for (int i = 1; i <= 5; i++) re(1, i == 1, 0, i == 5, 0, 0, 58);
      idle(6);
      chk("ovf_set2", o_ovf, 1);
      re(0, 0, 0, 0, 1, 1, 0);
      idle(3);
      chk("ovf_clr_1st", o_ovf, 0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      chk("drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
